// File: rtl/sf_pkt_buffer_pkg.sv
// sf_pkt_buffer_pkg: shared state encodings and NetFPGA ctrl codes
package sf_pkt_buffer_pkg;
  typedef enum logic [1:0] {
    S_RX   = 2'd0,
    S_TX   = 2'd1,
    S_DROP = 2'd2
  } state_e;
  localparam logic [7:0] CTRL_MOD_HDR = 8'hFF;
  localparam logic [7:0] CTRL_PAYLOAD = 8'h00;
endpackage

// File: rtl/sf_buffer_ram.sv
// sf_buffer_ram: packet word store with one synchronous write port and one combinational read port
module sf_buffer_ram #(
  parameter int WIDTH      = 72,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  // store one word per accepted write; contents need no reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sf_pkt_buffer.sv
// sf_pkt_buffer: store-and-forward buffer holding one packet, dropping packets larger than the buffer
module sf_pkt_buffer
  import sf_pkt_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_ptr_q, last_ptr_d;
  logic seen_q, seen_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d, drop_q, drop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic out_wr_q, out_wr_d;
  logic accept, payload, eop, full, we;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] rdata;

  assign in_rdy = state_q == S_RX || state_q == S_DROP;
  assign accept = in_wr && in_rdy;
  assign payload = in_ctrl == CTRL_WIDTH'(CTRL_PAYLOAD);
  assign eop = accept && seen_q && !payload;
  assign full = wr_ptr_q == PW'(DEPTH);
  assign we = accept && state_q == S_RX && !full;

  sf_buffer_ram #(
    .WIDTH      (DATA_WIDTH + CTRL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i ({in_ctrl, in_data}),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  // next-state: receive into RAM, discard oversize packets, drain stored packet when downstream is ready
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_ptr_d = last_ptr_q;
    seen_d = seen_q || (accept && payload);
    pkt_d = pkt_q;
    drop_d = drop_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    out_wr_d = 1'b0;
    case (state_q)
      S_RX: begin
        if (accept && full && eop) begin
          drop_d = drop_q + 1'b1;
          wr_ptr_d = '0;
          seen_d = 1'b0;
        end else if (accept && full) begin
          state_d = S_DROP;
        end else if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (eop) begin
            last_ptr_d = wr_ptr_q;
            state_d = S_TX;
            seen_d = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (eop) begin
          drop_d = drop_q + 1'b1;
          wr_ptr_d = '0;
          state_d = S_RX;
          seen_d = 1'b0;
        end
      end
      S_TX: begin
        if (out_rdy) begin
          out_wr_d = 1'b1;
          out_data_d = rdata[DATA_WIDTH-1:0];
          out_ctrl_d = rdata[DATA_WIDTH+:CTRL_WIDTH];
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == last_ptr_q) begin
            pkt_d = pkt_q + 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d = S_RX;
          end
        end
      end
      default: state_d = S_RX;
    endcase
  end

  // state, pointers, counters and registered output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RX;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_ptr_q <= '0;
      seen_q <= 1'b0;
      pkt_q <= '0;
      drop_q <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_ptr_q <= last_ptr_d;
      seen_q <= seen_d;
      pkt_q <= pkt_d;
      drop_q <= drop_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q <= out_wr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr = out_wr_q;
  assign pkt_count = pkt_q;
  assign drop_count = drop_q;
  assign busy = state_q == S_TX;
endmodule

// File: tb/tb_sf_pkt_buffer.sv
// tb_sf_pkt_buffer: packet-level model and directed scenarios for sf_pkt_buffer
module tb_sf_pkt_buffer;
  import sf_pkt_buffer_pkg::*;
  localparam int AW = 3;
  localparam int DEPTH = 2 ** AW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0] in_ctrl = '0;
  logic in_wr = 1'b0;
  logic in_rdy;
  logic [63:0] out_data;
  logic [7:0] out_ctrl;
  logic out_wr;
  logic out_rdy = 1'b1;
  logic [31:0] pkt_count, drop_count;
  logic busy;
  int tests = 0;
  int fails = 0;
  int nout = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  logic [63:0] expd[$], pd[$], got_d[$];
  logic [7:0] expc[$], pc[$], got_c[$];
  logic [63:0] cd;
  logic [7:0] cc;

  sf_pkt_buffer #(
    .DATA_WIDTH (64),
    .CTRL_WIDTH (8),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr      (in_wr),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // every emitted word must be the next word the packet model says is due
  always @(negedge clk) begin
    tests++;
    if (in_rdy === busy) begin
      fails++;
      $display("FAIL rdy_vs_busy: in_rdy=%b busy=%b", in_rdy, busy);
    end
    if (out_wr === 1'b1) begin
      tests++;
      got_d.push_back(out_data);
      got_c.push_back(out_ctrl);
      nout++;
      if (expd.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_wr: got data=%h ctrl=%h, none due", out_data, out_ctrl);
      end else begin
        cd = expd.pop_front();
        cc = expc.pop_front();
        if (out_data !== cd || out_ctrl !== cc) begin
          fails++;
          $display("FAIL out_word: got %h/%h expected %h/%h", out_data, out_ctrl, cd, cc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mkpkt(input int n, input logic [63:0] step);
    pd.delete();
    pc.delete();
    for (int i = 0; i < n; i++) begin
      pd.push_back(step * 64'(i + 1));
      pc.push_back(i == 0 ? CTRL_MOD_HDR : (i == n - 1 ? 8'h80 : CTRL_PAYLOAD));
    end
  endtask

  task automatic model_reset();
    expd.delete();
    expc.delete();
    exp_pkt = 0;
    exp_drop = 0;
  endtask

  task automatic send(output int waits);
    int to;
    waits = 0;
    if (pd.size() <= DEPTH) begin
      foreach (pd[i]) begin
        expd.push_back(pd[i]);
        expc.push_back(pc[i]);
      end
      exp_pkt++;
    end else exp_drop++;
    foreach (pd[i]) begin
      in_wr = 1'b1;
      in_data = pd[i];
      in_ctrl = pc[i];
      to = 0;
      while (!in_rdy && to < 200) begin
        @(posedge clk); #1;
        to++;
        waits++;
      end
      chk("send_rdy", {63'd0, in_rdy}, 64'd1);
      @(posedge clk); #1;
    end
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while ((expd.size() != 0 || busy) && to < 300) begin
      @(posedge clk); #1;
      to++;
    end
    chk("drain_left", 64'(expd.size()), 64'd0);
    chk("pkt_count", {32'd0, pkt_count}, 64'(exp_pkt));
    chk("drop_count", {32'd0, drop_count}, 64'(exp_drop));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, n0;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk); #1;
    chk("por_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("por_out_wr", {63'd0, out_wr}, 64'd0);
    // plain 4-word packet
    got_d.delete(); got_c.delete();
    mkpkt(4, 64'h11);
    send(w);
    chk("eop_in_rdy_low", {63'd0, in_rdy}, 64'd0);
    drain();
    chk("p4_count", 64'(got_d.size()), 64'd4);
    chk("p4_w0_data", got_d[0], 64'h11);
    chk("p4_w0_ctrl", {56'd0, got_c[0]}, 64'hFF);
    chk("p4_w3_data", got_d[3], 64'h44);
    chk("p4_w3_ctrl", {56'd0, got_c[3]}, 64'h80);
    chk("p4_pkts_lit", {32'd0, pkt_count}, 64'd1);
    // asynchronous reset mid-cycle
    @(posedge clk); #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_out_wr", {63'd0, out_wr}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_pkt", {32'd0, pkt_count}, 64'd0);
    chk("rst_drop", {32'd0, drop_count}, 64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    // back-pressure after the second word
    got_d.delete(); got_c.delete();
    n0 = nout;
    mkpkt(4, 64'h11);
    send(w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_words_before_stall", 64'(nout - n0), 64'd2);
    chk("bp_out_wr_stalled", {63'd0, out_wr}, 64'd0);
    out_rdy = 1'b1;
    drain();
    chk("bp_words_total", 64'(nout - n0), 64'd4);
    chk("bp_w2_data", got_d[2], 64'h33);
    // oversize packet is dropped while staying ready
    n0 = nout;
    mkpkt(11, 64'h5);
    send(w);
    chk("ovf_waits", 64'(w), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_no_out", 64'(nout - n0), 64'd0);
    chk("ovf_drop_lit", {32'd0, drop_count}, 64'd1);
    chk("ovf_in_rdy", {63'd0, in_rdy}, 64'd1);
    mkpkt(4, 64'h100);
    send(w);
    drain();
    chk("ovf_next_words", 64'(nout - n0), 64'd4);
    // exact-fit packet
    n0 = nout;
    mkpkt(DEPTH, 64'h7);
    send(w);
    drain();
    chk("fit_words", 64'(nout - n0), 64'(DEPTH));
    chk("fit_drop_lit", {32'd0, drop_count}, 64'd1);
    // reset during transmit after two words
    mkpkt(4, 64'h9);
    send(w);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("txrst_out_wr", {63'd0, out_wr}, 64'd0);
    chk("txrst_busy", {63'd0, busy}, 64'd0);
    chk("txrst_pkt", {32'd0, pkt_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    got_d.delete(); got_c.delete();
    mkpkt(4, 64'hA0);
    send(w);
    drain();
    chk("txrst_first_word", got_d[0], 64'hA0);
    chk("txrst_pkt_lit", {32'd0, pkt_count}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
